// File: rtl/mem_arbiter_pkg.sv
// Shared widths, requester ids and FSM encoding for the memory arbiter slice.
package mem_arbiter_pkg;

  localparam int ROB_SIZE_WIDTH       = 4;
  localparam int LOAD_TYPE_NUM_WIDTH  = 3;
  localparam int STORE_TYPE_NUM_WIDTH = 2;

  // Requester ids double as bit positions in one-hot vectors; a higher id means higher fixed priority.
  localparam int NUM_REQ = 3;
  localparam int ID_IC   = 0;
  localparam int ID_LSB  = 1;
  localparam int ID_ROB  = 2;

  localparam logic [2:0] MC_TYPE_FETCH = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-controller signals of the arbiter; slave = arbiter side, master = environment.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                            ic_req;
  logic [31:0]                     ic_addr;
  logic                            lsb_req;
  logic [31:0]                     lsb_addr;
  logic [LOAD_TYPE_NUM_WIDTH-1:0]  lsb_load_type;
  logic [ROB_SIZE_WIDTH-1:0]       lsb_tag;
  logic                            rob_req;
  logic [31:0]                     rob_addr;
  logic [31:0]                     rob_din;
  logic [STORE_TYPE_NUM_WIDTH-1:0] rob_store_type;

  logic                            ic_gnt;
  logic                            lsb_gnt;
  logic                            rob_gnt;
  logic                            rob_done;

  logic                            mc_ic_valid;
  logic                            mc_lsb_valid;
  logic                            mc_rob_valid;
  logic [31:0]                     mc_addr;
  logic [31:0]                     mc_din;
  logic [2:0]                      mc_type;
  logic [ROB_SIZE_WIDTH-1:0]       mc_tag;
  logic                            mc_busy;
  logic                            mc_dout_ready;
  logic                            mc_iout_ready;

  modport slave (
    input  ic_req, ic_addr, lsb_req, lsb_addr, lsb_load_type, lsb_tag,
           rob_req, rob_addr, rob_din, rob_store_type,
           mc_busy, mc_dout_ready, mc_iout_ready,
    output ic_gnt, lsb_gnt, rob_gnt, rob_done,
           mc_ic_valid, mc_lsb_valid, mc_rob_valid, mc_addr, mc_din, mc_type, mc_tag
  );

  modport master (
    output ic_req, ic_addr, lsb_req, lsb_addr, lsb_load_type, lsb_tag,
           rob_req, rob_addr, rob_din, rob_store_type,
           mc_busy, mc_dout_ready, mc_iout_ready,
    input  ic_gnt, lsb_gnt, rob_gnt, rob_done,
           mc_ic_valid, mc_lsb_valid, mc_rob_valid, mc_addr, mc_din, mc_type, mc_tag
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: fixed priority rob > lsb > ic, with an optional ic starvation override.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter bit               STARVE_EN = 1'b0,
  parameter int               CNT_W     = 3,
  parameter logic [CNT_W-1:0] LIMIT     = '0
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [CNT_W-1:0]   starve_cnt,
  output logic [NUM_REQ-1:0] win
);

  logic [NUM_REQ-1:0] fixed_win;
  logic               ic_starved;

  // A requester wins the fixed ladder when nobody with a higher id is asking.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_prio
      assign fixed_win[gi] = req_vec[gi] && ((req_vec >> (gi + 1)) == '0);
    end
  endgenerate

  assign ic_starved = STARVE_EN && req_vec[ID_IC] && (starve_cnt >= LIMIT);

  always_comb begin
    win = fixed_win;
    if (ic_starved) begin
      win        = '0;
      win[ID_IC] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter (IDLE -> ISSUE -> WAIT) for fetch, load and store requesters.
// Define MEM_ARB_STARVE_EN to let a starving ic request override the fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk_in,
  input logic          rst_in,
  input logic          rdy_in,
  input logic          need_flush_in,
  mem_arbiter_if.slave bus
);

  localparam int               CNT_W   = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  state_e                    state_reg, state_next;
  logic [NUM_REQ-1:0]        owner_reg, owner_next;
  logic [NUM_REQ-1:0]        gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]        valid_reg, valid_next;
  logic                      rob_done_reg, rob_done_next;
  logic [31:0]               addr_reg, addr_next;
  logic [31:0]               din_reg, din_next;
  logic [2:0]                type_reg, type_next;
  logic [ROB_SIZE_WIDTH-1:0] tag_reg, tag_next;

  logic [NUM_REQ-1:0]        req_vec;
  logic [NUM_REQ-1:0]        win;
  logic                      arb_fire;
  logic [CNT_W-1:0]          starve_cnt;

  assign req_vec[ID_IC]  = bus.ic_req;
  assign req_vec[ID_LSB] = bus.lsb_req;
  assign req_vec[ID_ROB] = bus.rob_req;

  assign arb_fire = (state_reg == ST_IDLE) && !need_flush_in && (|req_vec) && !bus.mc_busy;

`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

  assign starve_cnt = starve_cnt_reg;

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (need_flush_in) begin
      starve_cnt_next = '0;
    end else if (arb_fire) begin
      if (win[ID_IC]) begin
        starve_cnt_next = '0;
      end else if (bus.ic_req && (starve_cnt_reg < LIMIT_C)) begin
        starve_cnt_next = starve_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      starve_cnt_reg <= '0;
    end else if (rdy_in) begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`else
  localparam bit STARVE_EN = 1'b0;
  assign starve_cnt = '0;
`endif

  mem_arb_pick #(
    .STARVE_EN (STARVE_EN),
    .CNT_W     (CNT_W),
    .LIMIT     (LIMIT_C)
  ) u_pick (
    .req_vec    (req_vec),
    .starve_cnt (starve_cnt),
    .win        (win)
  );

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    gnt_next      = '0;
    valid_next    = '0;
    rob_done_next = 1'b0;
    addr_next     = addr_reg;
    din_next      = din_reg;
    type_next     = type_reg;
    tag_next      = tag_reg;
    // Flush beats everything, including a completion arriving in the same cycle.
    if (need_flush_in) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arb_fire) begin
            state_next = ST_ISSUE;
            owner_next = win;
            gnt_next   = win;
            if (win[ID_ROB]) begin
              addr_next = bus.rob_addr;
              din_next  = bus.rob_din;
              type_next = {1'b0, bus.rob_store_type};
            end else if (win[ID_LSB]) begin
              addr_next = bus.lsb_addr;
              type_next = bus.lsb_load_type;
              tag_next  = bus.lsb_tag;
            end else begin
              addr_next = bus.ic_addr;
              type_next = MC_TYPE_FETCH;
            end
          end
        end
        ST_ISSUE: begin
          valid_next = owner_reg;
          state_next = ST_WAIT;
        end
        ST_WAIT: begin
          if ((owner_reg[ID_IC] && bus.mc_iout_ready) || (owner_reg[ID_LSB] && bus.mc_dout_ready)) begin
            state_next = ST_IDLE;
          end else if (owner_reg[ID_ROB] && !bus.mc_busy) begin
            state_next    = ST_IDLE;
            rob_done_next = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= '0;
      gnt_reg      <= '0;
      valid_reg    <= '0;
      rob_done_reg <= 1'b0;
      addr_reg     <= '0;
      din_reg      <= '0;
      type_reg     <= '0;
      tag_reg      <= '0;
    end else if (rdy_in) begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      gnt_reg      <= gnt_next;
      valid_reg    <= valid_next;
      rob_done_reg <= rob_done_next;
      addr_reg     <= addr_next;
      din_reg      <= din_next;
      type_reg     <= type_next;
      tag_reg      <= tag_next;
    end
  end

  assign bus.ic_gnt       = gnt_reg[ID_IC];
  assign bus.lsb_gnt      = gnt_reg[ID_LSB];
  assign bus.rob_gnt      = gnt_reg[ID_ROB];
  assign bus.rob_done     = rob_done_reg;
  assign bus.mc_ic_valid  = valid_reg[ID_IC];
  assign bus.mc_lsb_valid = valid_reg[ID_LSB];
  assign bus.mc_rob_valid = valid_reg[ID_ROB];
  assign bus.mc_addr      = addr_reg;
  assign bus.mc_din       = din_reg;
  assign bus.mc_type      = type_reg;
  assign bus.mc_tag       = tag_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transaction-level bench for mem_arbiter with directed flush, stall and reset cases.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic need_flush_in;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .need_flush_in (need_flush_in),
    .bus           (bus)
  );

  always #5 clk_in = ~clk_in;

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int starve_m = 0;
  int txn_no   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [2:0] gnt_vec();
    return {bus.rob_gnt, bus.lsb_gnt, bus.ic_gnt};
  endfunction

  function automatic logic [2:0] valid_vec();
    return {bus.mc_rob_valid, bus.mc_lsb_valid, bus.mc_ic_valid};
  endfunction

  // Model: 2 = rob, 1 = lsb, 0 = ic
  function automatic int winner_model();
    if (STARVE_ON && bus.ic_req && (starve_m >= LIMIT)) return 0;
    if (bus.rob_req) return 2;
    if (bus.lsb_req) return 1;
    return 0;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"},   32'(gnt_vec()),   32'd0);
    check_eq({tag, "_valid"}, 32'(valid_vec()), 32'd0);
    check_eq({tag, "_done"},  32'(bus.rob_done), 32'd0);
    check_eq({tag, "_addr"},  bus.mc_addr,      32'd0);
    check_eq({tag, "_din"},   bus.mc_din,       32'd0);
    check_eq({tag, "_type"},  32'(bus.mc_type), 32'd0);
    check_eq({tag, "_tag"},   32'(bus.mc_tag),  32'd0);
  endtask

  task automatic raise_rob();
    bus.rob_req        = 1'b1;
    bus.rob_addr       = $urandom;
    bus.rob_din        = $urandom;
    bus.rob_store_type = 2'($urandom_range(0, 3));
  endtask

  task automatic raise_lsb();
    bus.lsb_req       = 1'b1;
    bus.lsb_addr      = $urandom;
    bus.lsb_load_type = 3'($urandom_range(0, 7));
    bus.lsb_tag       = 4'($urandom_range(0, 15));
  endtask

  task automatic raise_ic();
    bus.ic_req  = 1'b1;
    bus.ic_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_requests();
    if (!bus.rob_req && $urandom_range(0, 2) == 0) raise_rob();
    if (!bus.lsb_req && $urandom_range(0, 1) == 1) raise_lsb();
    if (!bus.ic_req && $urandom_range(0, 1) == 1) raise_ic();
    if (!(bus.rob_req || bus.lsb_req || bus.ic_req)) raise_ic();
  endtask

  // One complete transaction starting with the arbiter idle and at least one request pending.
  task automatic run_txn();
    int          id;
    int          nb;
    int          nd;
    logic [31:0] e_addr;
    logic [31:0] e_din;
    logic [2:0]  e_type;
    logic [3:0]  e_tag;
    string       nm;

    nb = $urandom_range(0, 2);
    repeat (nb) begin
      bus.mc_busy = 1'b1;
      tick();
      check_eq("busy_blocks_gnt", 32'(gnt_vec()), 32'd0);
    end
    bus.mc_busy = 1'b0;

    id     = winner_model();
    e_din  = bus.rob_din;
    e_tag  = bus.lsb_tag;
    if (id == 2) begin
      e_addr = bus.rob_addr; e_type = {1'b0, bus.rob_store_type}; nm = "rob";
    end else if (id == 1) begin
      e_addr = bus.lsb_addr; e_type = bus.lsb_load_type; nm = "lsb";
    end else begin
      e_addr = bus.ic_addr; e_type = 3'b010; nm = "ic";
    end
    if (bus.ic_req) starve_m = (id == 0) ? 0 : ((starve_m < LIMIT) ? starve_m + 1 : starve_m);

    tick();
    check_eq("gnt", 32'(gnt_vec()), 32'(1 << id));
    if (id == 2) bus.mc_busy = 1'b1;

    tick();
    check_eq("issue_valid", 32'(valid_vec()), 32'(1 << id));
    check_eq("issue_gnt_clear", 32'(gnt_vec()), 32'd0);
    check_eq("issue_addr", bus.mc_addr, e_addr);
    check_eq("issue_type", 32'(bus.mc_type), 32'(e_type));
    if (id == 2) check_eq("issue_din", bus.mc_din, e_din);
    if (id == 1) check_eq("issue_tag", 32'(bus.mc_tag), 32'(e_tag));

    // Wiggle completions that belong to other requesters; none may end this transaction.
    nd = $urandom_range(0, 3);
    repeat (nd) begin
      if (id != 1) bus.mc_dout_ready = 1'($urandom_range(0, 1));
      if (id != 0) bus.mc_iout_ready = 1'($urandom_range(0, 1));
      if (id != 2) bus.mc_busy       = 1'($urandom_range(0, 1));
      tick();
      check_eq("wait_gnt", 32'(gnt_vec()), 32'd0);
      check_eq("wait_valid", 32'(valid_vec()), 32'd0);
      check_eq("wait_done", 32'(bus.rob_done), 32'd0);
    end
    bus.mc_dout_ready = 1'b0;
    bus.mc_iout_ready = 1'b0;
    bus.mc_busy       = 1'b0;
    if (id == 1) bus.mc_dout_ready = 1'b1;
    if (id == 0) bus.mc_iout_ready = 1'b1;

    tick();
    check_eq("complete_done", 32'(bus.rob_done), (id == 2) ? 32'd1 : 32'd0);
    check_eq("complete_gnt", 32'(gnt_vec()), 32'd0);
    bus.mc_dout_ready = 1'b0;
    bus.mc_iout_ready = 1'b0;
    if (id == 2) bus.rob_req = 1'b0;
    if (id == 1) bus.lsb_req = 1'b0;
    if (id == 0) bus.ic_req  = 1'b0;

    txn_no++;
    $display("txn %0d: %s granted addr=0x%08h type=%0d starve_model=%0d", txn_no, nm, e_addr, e_type, starve_m);
  endtask

  initial begin
    logic [31:0] a_exp;
    logic [31:0] d_exp;

    rst_in            = 1'b1;
    rdy_in            = 1'b1;
    need_flush_in     = 1'b0;
    bus.ic_req        = 1'b0; bus.ic_addr = '0;
    bus.lsb_req       = 1'b0; bus.lsb_addr = '0; bus.lsb_load_type = '0; bus.lsb_tag = '0;
    bus.rob_req       = 1'b0; bus.rob_addr = '0; bus.rob_din = '0; bus.rob_store_type = '0;
    bus.mc_busy       = 1'b0;
    bus.mc_dout_ready = 1'b0;
    bus.mc_iout_ready = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_in = 1'b0;

    // Fetch only at 0x100.
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h100;
    run_txn();

    // Store and load together: store first, load after the bubble.
    raise_rob();
    raise_lsb();
    run_txn();
    run_txn();

    // Held fetch competing with repeated loads.
    raise_ic();
    for (int k = 0; k < 5; k++) begin
      if (!bus.lsb_req) raise_lsb();
      run_txn();
    end

    for (int k = 0; k < 60; k++) begin
      new_requests();
      run_txn();
    end

    // Flush in idle with requests pending: nothing is granted, then drop everything.
    need_flush_in = 1'b1;
    tick();
    check_eq("flush_idle_gnt", 32'(gnt_vec()), 32'd0);
    need_flush_in = 1'b0;
    bus.ic_req = 1'b0; bus.lsb_req = 1'b0; bus.rob_req = 1'b0;
    starve_m = 0;
    tick();

    // Store interrupted by a flush that coincides with its completion, then reissued.
    raise_rob();
    a_exp = bus.rob_addr;
    d_exp = bus.rob_din;
    tick();
    check_eq("fl_gnt", 32'(gnt_vec()), 32'd4);
    bus.mc_busy = 1'b1;
    tick();
    check_eq("fl_valid", 32'(valid_vec()), 32'd4);
    check_eq("fl_addr", bus.mc_addr, a_exp);
    tick();
    need_flush_in = 1'b1;
    bus.mc_busy   = 1'b0;
    tick();
    check_eq("fl_no_done", 32'(bus.rob_done), 32'd0);
    check_eq("fl_no_gnt", 32'(gnt_vec()), 32'd0);
    need_flush_in = 1'b0;
    tick();
    check_eq("fl_regnt", 32'(gnt_vec()), 32'd4);
    bus.mc_busy = 1'b1;
    tick();
    check_eq("fl_revalid", 32'(valid_vec()), 32'd4);
    check_eq("fl_readdr", bus.mc_addr, a_exp);
    check_eq("fl_redin", bus.mc_din, d_exp);
    bus.mc_busy = 1'b0;
    tick();
    check_eq("fl_done", 32'(bus.rob_done), 32'd1);
    bus.rob_req = 1'b0;
    tick();
    check_eq("fl_done_once", 32'(bus.rob_done), 32'd0);

    // Stall in ISSUE, then reset in WAIT.
    raise_rob();
    tick();
    check_eq("st_gnt", 32'(gnt_vec()), 32'd4);
    rdy_in      = 1'b0;
    bus.mc_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("st_frozen_valid", 32'(valid_vec()), 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    check_eq("st_valid", 32'(valid_vec()), 32'd4);
    tick();
    check_eq("st_valid_once", 32'(valid_vec()), 32'd0);
    check_eq("st_no_done", 32'(bus.rob_done), 32'd0);
    rst_in = 1'b1;
    tick();
    check_all_zero("midwait_reset");
    rst_in      = 1'b0;
    bus.rob_req = 1'b0;
    bus.mc_busy = 1'b0;
    starve_m    = 0;
    tick();

    // rdy low in idle blocks arbitration.
    rdy_in = 1'b0;
    raise_ic();
    tick();
    tick();
    check_eq("rdy_low_gnt", 32'(gnt_vec()), 32'd0);
    rdy_in = 1'b1;
    run_txn();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive lost arbitrations after which a waiting ic request wins.
REQ-002 clk_in  input  1  system clock; one clock domain.
REQ-003 rst_in  input  1  synchronous, active-high reset.
REQ-004 rdy_in  input  1  global enable; low freezes all state.
REQ-005 need_flush_in  input  1  pipeline flush.
REQ-006 ic_req  input  1  icache fetch request, held until mc_iout_ready or flush.
REQ-007 ic_addr  input  32  fetch address.
REQ-008 lsb_req  input  1  load request, held until mc_dout_ready or flush.
REQ-009 lsb_addr  input  32  load address.
REQ-010 lsb_load_type  input  LOAD_TYPE_NUM_WIDTH  load size/sign.
REQ-011 lsb_tag  input  ROB_SIZE_WIDTH  RoB index of the load.
REQ-012 rob_req  input  1  committed store request, held until rob_done.
REQ-013 rob_addr  input  32  store address.
REQ-014 rob_din  input  32  store data.
REQ-015 rob_store_type  input  STORE_TYPE_NUM_WIDTH  store size.
REQ-016 ic_gnt / lsb_gnt / rob_gnt  output  1 each  one-cycle pulse marking the winner.
REQ-017 rob_done  output  1  one-cycle pulse when the store has fully left the memory controller.
REQ-018 mc_ic_valid / mc_lsb_valid / mc_rob_valid  output  1 each  one-hot issue strobe to the memory controller.
REQ-019 mc_addr  output  32  issued address.
REQ-020 mc_din  output  32  issued store data.
REQ-021 mc_type  output  3  lsb: lsb_load_type; rob: {1'b0, rob_store_type}; ic: 3'b010.
REQ-022 mc_tag  output  ROB_SIZE_WIDTH  issued lsb_tag.
REQ-023 mc_busy  input  1  memory controller busy.
REQ-024 mc_dout_ready, mc_iout_ready  input  1 each  load / fetch completion from the memory controller.

Function
REQ-025 FSM states IDLE, ISSUE, WAIT; at most one transaction outstanding.
REQ-026 IDLE: when any request is pending and mc_busy=0, latch the winner's fields, pulse its gnt, go to ISSUE; otherwise stay.
REQ-027 Priority: rob > lsb > ic; an ic request wins over both once starve_cnt >= STARVE_LIMIT.
REQ-028 starve_cnt: +1 (saturating) on each arbitration ic loses while ic_req=1; cleared when ic wins.
REQ-029 ISSUE: drive exactly one mc_*_valid high for exactly one cycle with latched mc_addr/mc_din/mc_type/mc_tag; go to WAIT.
REQ-030 WAIT: complete on mc_iout_ready (ic), mc_dout_ready (lsb), or first cycle mc_busy=0 (rob, also pulse rob_done); go to IDLE.
REQ-031 Earliest next issue: the cycle after returning to IDLE (one bubble between transactions).
REQ-032 Outside ISSUE, all mc_*_valid = 0; mc_addr/mc_din/mc_type/mc_tag hold their last value.
REQ-033 need_flush_in=1 in any state: go to IDLE, no gnt, no rob_done, clear starve_cnt; an interrupted store is reissued in full from the still-held rob_req.
REQ-034 Flush and completion in the same cycle: flush wins; no rob_done.
REQ-035 rdy_in=0: state, counters and outputs hold; pulses do not repeat.

Reset
REQ-036 rst_in=1 at a clock edge: state IDLE, starve_cnt 0, all gnt, rob_done, mc_*_valid = 0, mc_addr/mc_din/mc_type/mc_tag = 0; overrides rdy_in and flush.

Configuration
REQ-037 MEM_ARB_STARVE_EN defined: REQ-027/028 starvation override active; undefined: pure fixed priority rob > lsb > ic, no starve_cnt, STARVE_LIMIT unused.

Structure
REQ-038 ROB_SIZE_WIDTH, LOAD_TYPE_NUM_WIDTH, STORE_TYPE_NUM_WIDTH and the requester-id and FSM encodings live in the shared const_param include.
REQ-039 One combinational sub-module, mem_arb_pick (requests + starve_cnt -> one-hot winner); the FSM stays in mem_arbiter.

Verification
REQ-040 ic_req only, addr 0x100: ic_gnt next cycle, mc_ic_valid one cycle later with mc_addr=0x100, mc_type=3'b010; IDLE after mc_iout_ready.
REQ-041 rob_req and lsb_req in the same cycle: rob_gnt first, rob_done after mc_busy falls; lsb issues after one bubble with its tag on mc_tag.
REQ-042 STARVE_EN, limit 4, ic_req and lsb_req held: 4 lsb grants, then ic granted; starve_cnt returns to 0.
REQ-043 Flush during WAIT of a store: no rob_done; store reissued with identical mc_addr/mc_din; rob_done once.
REQ-044 rdy_in low for 3 cycles in ISSUE: mc_rob_valid asserted for exactly one enabled cycle; reset mid-WAIT: all outputs 0 next cycle.
